// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART key receiver: receiver state encoding,
// baud divider calculation and the default key map.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit per frame).
package uart_rx_pkg;

    // Receiver states; PARITY only exists when the parity bit is enabled.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rxState_e;

    // Eight keys, leftmost byte lands on the highest output bit.
    localparam logic [63:0] DEFAULT_KEY_MAP = {"a", "s", "d", "f", "z", "x", "c", "v"};

    // Clocks per oversample tick, clamped so a too-fast baud still ticks every cycle.
    function automatic int calcDiv(input int clkFreq, input int baudRate, input int overSample);
        int div;
        div = clkFreq / (baudRate * overSample);
        if (div < 1) begin
            div = 1;
        end
        return div;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receive core: two-flop line synchroniser, free-running oversample tick
// and the frame FSM producing rx_data/rx_valid/frame_err.
// Optional feature macro: UART_RX_PARITY_EN (even parity between data and stop).
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_err_o
);

    localparam int DIV   = calcDiv(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  SMPL_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SMPL_LAST = OS_W'(OVERSAMPLE - 1);

    logic [1:0]       sync_q;
    logic             line;
    logic [DIV_W-1:0] divCnt_q;
    logic             tick;

    rxState_e         state_q, state_d;
    logic [OS_W-1:0]  smplCnt_q, smplCnt_d;
    logic [2:0]       bitCnt_q, bitCnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rxData_q, rxData_d;
    logic             rxValid_q, rxValid_d;
    logic             frameErr_q, frameErr_d;
    logic             break_q, break_d;
    logic             frameOk;

    // Bring the asynchronous line into the clock domain; idles high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_i};
        end
    end

    assign line = sync_q[1];

    // Free-running divider; the wrap cycle is the oversample tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divCnt_q <= '0;
        end else if (divCnt_q == DIV_LAST) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_q + 1'b1;
        end
    end

    assign tick = (divCnt_q == DIV_LAST);

`ifdef UART_RX_PARITY_EN
    logic parityErr_q, parityErr_d;

    // Parity verdict is held from the PARITY mid-sample until the stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parityErr_q <= 1'b0;
        end else begin
            parityErr_q <= parityErr_d;
        end
    end

    assign frameOk = ~parityErr_q;
`else
    assign frameOk = 1'b1;
`endif

    // Frame state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            smplCnt_q  <= '0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            break_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            smplCnt_q  <= smplCnt_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            rxData_q   <= rxData_d;
            rxValid_q  <= rxValid_d;
            frameErr_q <= frameErr_d;
            break_q    <= break_d;
        end
    end

    // Next-state logic. Every state counts ticks within the current bit,
    // samples at the mid tick and moves on at the last tick; STOP returns to
    // IDLE at its mid tick so a following start edge is not missed. A held-low
    // line reports one framing error and stays quiet until it goes high again.
    always_comb begin
        state_d    = state_q;
        smplCnt_d  = smplCnt_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        rxData_d   = rxData_q;
        rxValid_d  = 1'b0;
        frameErr_d = 1'b0;
        break_d    = break_q & ~line;
`ifdef UART_RX_PARITY_EN
        parityErr_d = parityErr_q;
`endif

        case (state_q)
            IDLE: begin
                if (tick && !line) begin
                    state_d   = START;
                    smplCnt_d = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (smplCnt_q == SMPL_MID && line) begin
                        state_d   = IDLE;
                        smplCnt_d = '0;
                    end else if (smplCnt_q == SMPL_LAST) begin
                        state_d   = DATA;
                        smplCnt_d = '0;
                        bitCnt_d  = '0;
                    end else begin
                        smplCnt_d = smplCnt_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (smplCnt_q == SMPL_MID) begin
                        shift_d = {line, shift_q[7:1]};
                    end
                    if (smplCnt_q == SMPL_LAST) begin
                        smplCnt_d = '0;
                        if (bitCnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bitCnt_d = bitCnt_q + 3'd1;
                        end
                    end else begin
                        smplCnt_d = smplCnt_q + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (smplCnt_q == SMPL_MID) begin
                        parityErr_d = line ^ (^shift_q);
                    end
                    if (smplCnt_q == SMPL_LAST) begin
                        state_d   = STOP;
                        smplCnt_d = '0;
                    end else begin
                        smplCnt_d = smplCnt_q + 1'b1;
                    end
                end
            end
`endif

            STOP: begin
                if (tick) begin
                    if (smplCnt_q == SMPL_MID) begin
                        state_d   = IDLE;
                        smplCnt_d = '0;
                        if (line && frameOk) begin
                            rxData_d  = shift_q;
                            rxValid_d = 1'b1;
                        end else if (!break_q) begin
                            frameErr_d = 1'b1;
                        end
                        if (!line) begin
                            break_d = 1'b1;
                        end
                    end else begin
                        smplCnt_d = smplCnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                smplCnt_d = '0;
            end
        endcase
    end

    assign rx_data_o   = rxData_q;
    assign rx_valid_o  = rxValid_q;
    assign frame_err_o = frameErr_q;

endmodule

// File: rtl/uart_key_toggle_rx.sv
// UART key receiver top: decodes serial bytes with uart_rx_core and maps
// configured ASCII key codes onto output bits that toggle or pulse.
// Optional feature macro: UART_RX_PARITY_EN (handled inside uart_rx_core).
module uart_key_toggle_rx
    import uart_rx_pkg::*;
#(
    parameter int                    CLK_FREQ    = 100_000_000,
    parameter int                    BAUD_RATE   = 9_600,
    parameter int                    OVERSAMPLE  = 16,
    parameter int                    NUM_KEYS    = 8,
    parameter logic [NUM_KEYS*8-1:0] KEY_MAP     = DEFAULT_KEY_MAP,
    parameter int                    TOGGLE_MODE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uart_in,
    output logic [NUM_KEYS-1:0] out,
    output logic [7:0]          rx_data,
    output logic                rx_valid,
    output logic                frame_err
);

    logic [NUM_KEYS-1:0] keyHit;
    logic [NUM_KEYS-1:0] out_q, out_d;

    uart_rx_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .uart_i      (uart_in),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .frame_err_o (frame_err)
    );

    // Compare the received byte against every key slot; duplicates all hit.
    always_comb begin
        keyHit = '0;
        for (int j = 0; j < NUM_KEYS; j++) begin
            if (rx_data == KEY_MAP[8*j +: 8]) begin
                keyHit[j] = 1'b1;
            end
        end
    end

    // Toggle mode flips hit bits once per good byte; pulse mode drives them for one cycle.
    always_comb begin
        out_d = out_q;
        if (TOGGLE_MODE != 0) begin
            if (rx_valid) begin
                out_d = out_q ^ keyHit;
            end
        end else begin
            out_d = rx_valid ? keyHit : '0;
        end
    end

    // Output register, one cycle behind rx_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule
